// File: rtl/alu_arb_pkg.sv
// Shared widths and FSM encoding for the two-requester ALU arbiter.
package alu_arb_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned OPND_W = 16;
  localparam int unsigned RES_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu16.sv
// Team 16-bit combinational ALU: select S picks the operation on A/B, 32-bit result Z.
module alu16
  import alu_arb_pkg::*;
(
  input  logic [OP_W-1:0]   S,
  input  logic [OPND_W-1:0] A,
  input  logic [OPND_W-1:0] B,
  output logic [RES_W-1:0]  Z
);

  logic [OPND_W:0]   sum;
  logic [OPND_W:0]   inc;
  logic [OPND_W-1:0] diff;
  logic [OPND_W-1:0] rol;
  logic [4:0]        rsh;

  always_comb begin
    sum  = {1'b0, A} + {1'b0, B};
    inc  = {1'b0, A} + 17'd1;
    diff = A - B;
    rsh  = 5'd16 - {1'b0, B[3:0]};
    rol  = (A << B[3:0]) | (A >> rsh);
    Z    = '0;
    case (S)
      4'd0:    Z = {15'd0, sum};
      4'd1:    Z = {{16{diff[15]}}, diff};
      4'd2:    Z = {16'd0, A} * {16'd0, B};
      4'd3:    Z = {16'd0, A & B};
      4'd4:    Z = {16'd0, A | B};
      4'd5:    Z = {16'd0, A ^ B};
      4'd6:    Z = {16'd0, ~(A & B)};
      4'd7:    Z = {16'd0, ~(A | B)};
      4'd8:    Z = {16'd0, ~(A ^ B)};
      4'd9:    Z = {16'd0, A} << B[3:0];
      4'd10:   Z = {16'd0, A >> B[3:0]};
      4'd11:   Z = {16'd0, rol};
      4'd12:   Z = {16'd0, A};
      4'd13:   Z = {16'd0, B};
      4'd14:   Z = {15'd0, inc};
      default: Z = 32'd0 - {{16{A[15]}}, A};
    endcase
  end

endmodule

// File: rtl/alu_rr_pick2.sv
// Combinational 2-way round-robin picker; on contention the side not granted last wins.
module alu_rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       grant_idx
);

  always_comb begin
    grant_idx = valid[1] && (!valid[0] || !last_grant);
    grant     = 2'b00;
    if (valid != 2'b00) begin
      grant = grant_idx ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters with a registered response channel.
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters.
module alu_arbiter
  import alu_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [OPND_W-1:0] req0_a,
  input  logic [OPND_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [OPND_W-1:0] req1_a,
  input  logic [OPND_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [RES_W-1:0]  rsp_data,
`ifdef ALU_ARB_STATS_EN
  output logic              busy,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1
`else
  output logic              busy
`endif
);

  localparam int unsigned NREQ = 2;

  state_t              state_q, state_d;
  logic                last_grant_q;
  logic                id_q;
  logic [OP_W-1:0]     op_q;
  logic [OPND_W-1:0]   a_q, b_q;
  logic [RES_W-1:0]    rsp_data_q;
  logic                rsp_id_q;
  logic [NREQ-1:0]     grant;
  logic                grant_idx;
  logic [NREQ-1:0]     ready;
  logic                hs;
  logic [RES_W-1:0]    alu_z;

  alu_rr_pick2 u_pick (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Operands come only from registers, so requester churn never disturbs an op in flight.
  alu16 u_alu (
    .S (op_q),
    .A (a_q),
    .B (b_q),
    .Z (alu_z)
  );

  // Ready is gated by rst so both stay low while reset is asserted.
  assign ready      = (state_q == IDLE && !rst) ? grant : '0;
  assign hs         = |ready;
  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        op_q         <= grant_idx ? req1_op : req0_op;
        a_q          <= grant_idx ? req1_a  : req0_a;
        b_q          <= grant_idx ? req1_b  : req0_b;
        id_q         <= grant_idx;
        last_grant_q <= grant_idx;
      end
      if (state_q == EXEC) begin
        rsp_data_q <= alu_z;
        rsp_id_q   <= id_q;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [15:0] gnt_cnt0_q, gnt_cnt1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
    end else begin
      if (ready[0] && gnt_cnt0_q != 16'hFFFF) gnt_cnt0_q <= gnt_cnt0_q + 16'd1;
      if (ready[1] && gnt_cnt1_q != 16'hFFFF) gnt_cnt1_q <= gnt_cnt1_q + 16'd1;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: drivers push expected {id,data}, a monitor pops on each response.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [3:0]  req0_op;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [3:0]  req1_op;
  logic [15:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0] rsp_data;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [32:0] exp_q[$];
  logic [31:0] exp_tab[16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
`ifdef ALU_ARB_STATS_EN
    .busy       (busy),
    .gnt_cnt0   (gnt_cnt0),
    .gnt_cnt1   (gnt_cnt1)
`else
    .busy       (busy)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every accepted response must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("rsp_id", {31'd0, rsp_id}, {31'd0, e[32]});
        chk("rsp_data", rsp_data, e[31:0]);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send(input bit id, input logic [3:0] op, input logic [15:0] a, b,
                      input logic [31:0] exp, input bit push, output bit got);
    got = 1'b0;
    if (push) exp_q.push_back({id, exp});
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("send_accepted", {31'd0, got}, 32'd1);
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  // Both requesters stay valid for n ops; grants must alternate starting with req0.
  task automatic contend(input int n, input logic [15:0] a0, a1);
    int prev = 0;
    int acc;
    bit got;
    for (int k = 0; k < n; k++) exp_q.push_back({k[0], (k[0] ? {16'd0, a1} : {16'd0, a0})});
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = a0; req0_b = 16'd0;
    req1_valid = 1'b1; req1_op = 4'd0; req1_a = a1; req1_b = 16'd0;
    for (int k = 0; k < n; k++) begin
      got = 1'b0;
      for (int w = 0; w < 12 && !got; w++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin
          got = 1'b1;
          chk("contend_id", {31'd0, req1_ready}, {31'd0, k[0]});
          chk("contend_one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
      end
      chk("contend_accepted", {31'd0, got}, 32'd1);
      acc = cyc;
      if (k > 0) chk("contend_gap", acc - prev, 32'd3);
      prev = acc;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || busy) && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("drain", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, required finished");
    $fatal(1);
  end

  initial begin
    bit got;
    exp_tab[0]  = 32'd90;        exp_tab[1]  = 32'd66;
    exp_tab[2]  = 32'd936;       exp_tab[3]  = 32'd12;
    exp_tab[4]  = 32'd78;        exp_tab[5]  = 32'd66;
    exp_tab[6]  = 32'h0000FFF3;  exp_tab[7]  = 32'h0000FFB1;
    exp_tab[8]  = 32'h0000FFBD;  exp_tab[9]  = 32'h0004E000;
    exp_tab[10] = 32'd0;         exp_tab[11] = 32'h0000E004;
    exp_tab[12] = 32'd78;        exp_tab[13] = 32'd12;
    exp_tab[14] = 32'd79;        exp_tab[15] = 32'hFFFFFFB2;

    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(posedge clk); #1;

    // Contention straight out of reset.
    contend(4, 16'd1, 16'd2);
    drain();

    // Single op with latency check.
    send(1'b0, 4'd0, 16'd78, 16'd12, 32'd90, 1'b1, got);
    chk("single_exec_valid", {31'd0, rsp_valid}, 32'd0);
    chk("single_exec_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("single_resp_valid", {31'd0, rsp_valid}, 32'd1);
    drain();

    // Backpressure.
    rsp_ready = 1'b0;
    send(1'b1, 4'd2, 16'd78, 16'd12, 32'd936, 1'b1, got);
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_data", rsp_data, 32'd936);
      chk("bp_id", {31'd0, rsp_id}, 32'd1);
      chk("bp_ready_low", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("bp_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_after", {31'd0, busy}, 32'd0);
    drain();

    // All ops via req1.
    for (int op = 0; op < 16; op++) begin
      send(1'b1, op[3:0], 16'd78, 16'd12, exp_tab[op], 1'b1, got);
    end
    drain();

    // Reset in EXEC: op abandoned, req0 wins first contention afterwards.
    send(1'b0, 4'd2, 16'd78, 16'd12, 32'd936, 1'b0, got);
    req0_valid = 1'b1; req1_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    contend(2, 16'd5, 16'd6);
    drain();

`ifdef ALU_ARB_STATS_EN
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b0, 4'd12, 16'd7, 16'd0, 32'd7, 1'b1, got);
    send(1'b1, 4'd13, 16'd0, 16'd9, 32'd9, 1'b1, got);
    drain();
    chk("stats_cnt0", {16'd0, gnt_cnt0}, 32'd3);
    chk("stats_cnt1", {16'd0, gnt_cnt1}, 32'd1);
    force dut.gnt_cnt0_q = 16'hFFFF;
    #1;
    release dut.gnt_cnt0_q;
    send(1'b0, 4'd12, 16'd3, 16'd0, 32'd3, 1'b1, got);
    drain();
    chk("stats_sat", {16'd0, gnt_cnt0}, 32'h0000FFFF);
`endif

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
